// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer and the sequence FSM that consumes its output.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t               debouncer FSM state encoding (ST_IDLE, ST_SETTLE)
//   STABLE_CYCLES_SIM     short settle window for simulation
//   STABLE_CYCLES_BOARD   settle window for the real board clock (~10 ms at 100 MHz)
//   sat_inc_w8()          8-bit saturating increment helper

package input_debouncer_pkg;

  // One-hot encoding: every pattern other than these two is illegal,
  // and the FSM recovers from those patterns to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_SETTLE = 2'b10
  } state_t;

  localparam int STABLE_CYCLES_SIM   = 4;
  localparam int STABLE_CYCLES_BOARD = 1_000_000;

  localparam int DEFAULT_WIDTH    = 2;
  localparam int DEFAULT_CNT_W    = 20;
  localparam int DEFAULT_GLITCH_W = 8;

  // Saturating increment for 8-bit debug counters: holds at 8'hFF.
  function automatic logic [7:0] sat_inc_w8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs.
// Latency: 2 clk from d_i to q_o.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset, clears both stages to 0
//   d_i  in   WIDTH  asynchronous inputs
//   q_o  out  WIDTH  synchronised outputs (second stage)

module input_debouncer_sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;

  // Each bit is synchronised independently. A multi-bit change may land
  // in different cycles per bit; the settle window downstream absorbs the skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces raw switch/button inputs into a clean vector for the sequence FSM.
// Latency: input stable before edge E0 -> x_out/x_chg update on edge E0+STABLE_CYCLES+1.
// Backpressure: none; x_chg is a single-cycle strobe and the consumer must take it.
//
// Ports:
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous active-high reset
//   raw_in      in   WIDTH     asynchronous raw inputs
//   x_out       out  WIDTH     debounced vector
//   x_chg       out  1         one-cycle pulse in the cycle x_out takes a new value
//   settling    out  1         high while a candidate vector is being qualified
//   glitch_cnt  out  GLITCH_W  aborted/restarted settles, saturating at all-ones

module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = STABLE_CYCLES_SIM,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int GLITCH_W      = DEFAULT_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    raw_in,
  output logic [WIDTH-1:0]    x_out,
  output logic                x_chg,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // Count value at which the candidate has been seen STABLE_CYCLES times.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    cand_q, cand_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic                chg_q, chg_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W-1:0] glitch_inc;

  input_debouncer_sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (raw_in),
    .q_o (s)
  );

  // Saturating: holds at all-ones so the debug LEDs never roll back to a small value.
  assign glitch_inc = (&glitch_q) ? glitch_q : glitch_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      x_q      <= '0;
      chg_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      x_q      <= x_d;
      chg_q    <= chg_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    x_d      = x_q;
    chg_d    = 1'b0;
    glitch_d = glitch_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s != x_q) begin
          // The first differing sample already counts as one stable cycle.
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = '0;
        end
      end

      ST_SETTLE: begin
        if (s == cand_q) begin
          // Using >= instead of == also makes an out-of-range count commit
          // and return to idle rather than count up indefinitely.
          if (cnt_q >= CNT_LAST) begin
            x_d     = cand_q;
            chg_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (s == x_q) begin
          // The input bounced back to the committed value: abandon the candidate.
          cnt_d    = '0;
          glitch_d = glitch_inc;
          state_d  = ST_IDLE;
        end else begin
          // A third value appeared: start qualifying it from scratch.
          // x_out is untouched, so a multi-bit change never shows an intermediate vector.
          cand_d   = s;
          cnt_d    = CNT_ONE;
          glitch_d = glitch_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign x_out      = x_q;
  assign x_chg      = chg_q;
  assign settling   = (state_q == ST_SETTLE);
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer. A reference model built around consecutive
// equal samples predicts every output on every cycle. Directed scenarios add literal checks.
// Clock period 10; inputs are driven on the falling edge and outputs are compared there.

module tb_input_debouncer;
  import input_debouncer_pkg::*;

  localparam int W  = 2;
  localparam int SC = STABLE_CYCLES_SIM;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  raw_in;
  logic [W-1:0]  x_out;
  logic          x_chg;
  logic          settling;
  logic [GW-1:0] glitch_cnt;

  int total = 0;
  int bad   = 0;

  input_debouncer #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .CNT_W         (20),
    .GLITCH_W      (GW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .x_out      (x_out),
    .x_chg      (x_chg),
    .settling   (settling),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model tracks the committed vector and the run of consecutive identical
  // samples that differ from it. The run commits once it reaches SC samples.
  // A run that is broken before then counts as one glitch.
  logic [W-1:0] m_pipe0, m_pipe1;
  logic [W-1:0] exp_x;
  logic         exp_chg;
  int           exp_glitch;
  int           run_len;
  logic [W-1:0] run_val;

  always @(posedge clk) begin
    logic [W-1:0] smp;
    if (rst) begin
      m_pipe0 = '0; m_pipe1 = '0;
      exp_x = '0; exp_chg = 1'b0; exp_glitch = 0;
      run_len = 0; run_val = '0;
    end else begin
      smp = m_pipe1;
      exp_chg = 1'b0;
      if (smp == exp_x) begin
        if (run_len > 0) exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
        run_len = 0;
      end else if (run_len > 0 && smp == run_val) begin
        run_len = run_len + 1;
        if (run_len == SC) begin
          exp_x = smp;
          exp_chg = 1'b1;
          run_len = 0;
        end
      end else begin
        if (run_len > 0) exp_glitch = (exp_glitch < 255) ? exp_glitch + 1 : 255;
        run_val = smp;
        run_len = 1;
      end
      m_pipe1 = m_pipe0;
      m_pipe0 = raw_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, starting once the first reset edge has happened.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cyc_x_out",      32'(x_out),      32'(exp_x));
      chk("cyc_x_chg",      32'(x_chg),      32'(exp_chg));
      chk("cyc_settling",   32'(settling),   32'(run_len > 0));
      chk("cyc_glitch_cnt", 32'(glitch_cnt), 32'(exp_glitch));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw01;
    logic saw_chg;

    // 1: reset held with inputs high
    rst = 1'b1; raw_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_x_out", 32'(x_out), 32'h0);
      chk("rst_x_chg", 32'(x_chg), 32'h0);
      chk("rst_glitch", 32'(glitch_cnt), 32'h0);
    end
    rst = 1'b0; raw_in = 2'b00;
    cyc(8);

    // 2: 00 -> 10 commits on the 6th edge after the change
    raw_in = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lat_hold_x", 32'(x_out), 32'h0);
    end
    @(negedge clk);
    chk("lat_commit_x", 32'(x_out), 32'h2);
    chk("lat_commit_chg", 32'(x_chg), 32'h1);
    chk("model_commit_x", 32'(exp_x), 32'h2);
    @(negedge clk);
    chk("lat_chg_drop", 32'(x_chg), 32'h0);
    raw_in = 2'b00;
    cyc(10);

    // 3: a short 01 pulse is rejected as a glitch
    raw_in = 2'b01;
    cyc(2);
    raw_in = 2'b00;
    cyc(1);
    chk("glitch_settling_hi", 32'(settling), 32'h1);
    cyc(4);
    chk("glitch_settling_lo", 32'(settling), 32'h0);
    chk("glitch_x", 32'(x_out), 32'h0);
    chk("glitch_cnt1", 32'(glitch_cnt), 32'h1);

    // 4: 01 briefly, then 11 held -> restart, commits straight to 11
    saw01 = 1'b0;
    raw_in = 2'b01;
    cyc(2);
    raw_in = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (x_out == 2'b01) saw01 = 1'b1;
    end
    chk("restart_never_01", 32'(saw01), 32'h0);
    chk("restart_x", 32'(x_out), 32'h3);
    chk("restart_glitch", 32'(glitch_cnt), 32'h2);

    // 5: reset while settling with cnt=3
    raw_in = 2'b00;
    cyc(5);
    chk("midrst_settling", 32'(settling), 32'h1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    saw_chg = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (x_chg) saw_chg = 1'b1;
    end
    chk("midrst_no_chg", 32'(saw_chg), 32'h0);
    chk("midrst_x", 32'(x_out), 32'h0);
    chk("midrst_idle", 32'(settling), 32'h0);

    // 6: 300 single-cycle glitches saturate the counter
    for (int i = 0; i < 300; i++) begin
      raw_in = 2'b01;
      cyc(1);
      raw_in = 2'b00;
      cyc(1);
    end
    cyc(6);
    chk("sat_glitch", 32'(glitch_cnt), 32'd255);
    chk("model_sat_glitch", 32'(exp_glitch), 32'd255);
    chk("sat_x", 32'(x_out), 32'h0);

    // Randomised phase: random vectors and hold lengths, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      raw_in = W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cyc(int'($urandom_range(1, 2)));
        rst = 1'b0;
      end
      cyc(int'($urandom_range(1, 8)));
    end
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
